// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-frame sprite controller.
// Holds the PAUSE/RUN state enum and the walk-cycle frame sequence (0, 1, 0, 2).

package sprite_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int SEQ_LEN = 4;

    // Graphic frame for each sequence step, step 0 in the low bits: 0, 1, 0, 2.
    localparam logic [2*SEQ_LEN-1:0] FRAME_SEQ = {2'd2, 2'd0, 2'd1, 2'd0};

    // Graphic frame number shown at a given sequence step.
    function automatic logic [1:0] seq_frame(input logic [1:0] step);
        return FRAME_SEQ[{step, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/sprite_frame_seq.sv
// Walk-cycle sequencer: counts running ticks in hold_cnt, advances the
// 4-step sequence every FRAME_HOLD ticks and registers the ROM base address
// of the graphic frame selected by that step.

module sprite_frame_seq
    import sprite_pkg::*;
#(
    parameter int FRAME_HOLD = 16,
    parameter int SPR_PIXELS = 640,
    parameter int ADDRW      = 11
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             step_en,
    input  logic             clear,
    output logic [ADDRW-1:0] base_addr
);

    localparam int STEP_W = $clog2(SEQ_LEN);
    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(FRAME_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_next;
    logic [ADDRW-1:0]  addr_next;

    // Next hold count and step; clear wins over a coincident step.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hold_next = hold_cnt;
        step_next = step;
        if (clear) begin
            hold_next = '0;
            step_next = '0;
        end else if (step_en) begin
            if (hold_cnt == HOLD_MAX) begin
                hold_next = '0;
                step_next = step + 1'b1;
            end else begin
                hold_next = hold_cnt + 1'b1;
            end
        end
        addr_next = ADDRW'(seq_frame(step_next)) * ADDRW'(SPR_PIXELS);
    end

    // Counter, step and base address registers; base_addr tracks the step at the same edge.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            step      <= '0;
            base_addr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
            hold_cnt  <= hold_next;
            step      <= step_next;
            base_addr <= addr_next;
        end
    end

endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite controller. At the start of vertical blanking it moves the
// sprite horizontally and steps the walk cycle; on the blanking area of the
// line before the sprite's first line it pulses spr_start for the line engine.
// Optional feature macro: SPRITE_BOUNCE_EN (bounce between screen edges
// instead of wrapping through the full line width).

module sprite_motion
    import sprite_pkg::*;
#(
    parameter int CORDW      = 12,
    parameter int H_RES      = 1920,
    parameter int V_RES      = 1080,
    parameter int H_RES_FULL = 2200,
    parameter int V_RES_FULL = 1125,
    parameter int SPR_PIXELS = 640,
    parameter int SPR_DRAW_W = 384,
    parameter int ADDRW      = 11,
    parameter int SPEED_X    = 6,
    parameter int FRAME_HOLD = 16,
    parameter int START_X    = 0,
    parameter int START_Y    = 420
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             run,
    input  logic             dir_in,
    input  logic             load,
    input  logic [CORDW-1:0] load_x,
    input  logic [CORDW-1:0] load_y,
    output logic [CORDW-1:0] sprx,
    output logic [CORDW-1:0] spry,
    output logic [ADDRW-1:0] base_addr,
    output logic             spr_start,
    output logic             animate,
    output logic             dir
);

    localparam logic [CORDW:0] SPD = (CORDW+1)'(SPEED_X);
`ifdef SPRITE_BOUNCE_EN
    localparam logic [CORDW:0] X_MAX = (CORDW+1)'(H_RES - SPR_DRAW_W);
    logic unused_dir_in;
    assign unused_dir_in = dir_in;
`else
    localparam logic [CORDW:0] HRF = (CORDW+1)'(H_RES_FULL);
    localparam int unused_draw_w = SPR_DRAW_W;
`endif

    state_t         state;
    state_t         state_next;
    logic           tick;
    logic           move_en;
    logic [CORDW:0] x_ext;
    logic [CORDW:0] x_move;
    logic           dir_next;
    logic [CORDW-1:0] spry_cor;
    logic           start_hit;

    assign tick  = (sy == CORDW'(V_RES)) && (sx == '0);
    assign x_ext = {1'b0, sprx};

    // Start line is the one above the sprite, wrapping to the last blanking line for spry = 0.
    assign spry_cor  = (spry == '0) ? CORDW'(V_RES_FULL - 1) : spry - 1'b1;
    assign start_hit = (spry < CORDW'(V_RES_FULL)) && (sy == spry_cor) && (sx == CORDW'(H_RES));

    // PAUSE/RUN state register, updated only at frame ticks.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) state <= PAUSE;
        else     state <= state_next;
    end

    // Next state from run at a tick; a running tick moves unless a load takes priority.
    always_comb begin
        state_next = state;
        move_en    = 1'b0;
        if (tick) begin
            state_next = run ? RUN : PAUSE;
            move_en    = run && !load;
        end
    end

    // Next X position and direction, computed one bit wider than the coordinates.
    always_comb begin
        x_move   = x_ext;
`ifdef SPRITE_BOUNCE_EN
        dir_next = dir;
        if (dir) begin
            if (x_ext <= SPD) begin
                x_move   = '0;
                dir_next = 1'b0;
            end else begin
                x_move = x_ext - SPD;
            end
        end else begin
            if (x_ext + SPD >= X_MAX) begin
                x_move   = X_MAX;
                dir_next = 1'b1;
            end else begin
                x_move = x_ext + SPD;
            end
        end
`else
        dir_next = dir_in;
        if (dir_in) begin
            x_move = (x_ext >= SPD) ? x_ext - SPD : HRF - (SPD - x_ext);
        end else begin
            x_move = x_ext + SPD;
            if (x_move >= HRF) x_move = x_move - HRF;
        end
`endif
    end

    // Position and direction registers; load overrides the tick's move.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sprx <= CORDW'(START_X);
            spry <= CORDW'(START_Y);
            dir  <= 1'b1;
        end else if (load) begin
            sprx <= load_x;
            spry <= load_y;
        end else if (move_en) begin
            sprx <= x_move[CORDW-1:0];
            dir  <= dir_next;
        end
    end

    // One-cycle markers: animate after each tick, spr_start after the start coordinate.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            animate   <= 1'b0;
            spr_start <= 1'b0;
        end else begin
            animate   <= tick;
            spr_start <= start_hit;
        end
    end

    sprite_frame_seq #(
        .FRAME_HOLD (FRAME_HOLD),
        .SPR_PIXELS (SPR_PIXELS),
        .ADDRW      (ADDRW)
    ) u_frame_seq (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .step_en   (move_en),
        .clear     (load),
        .base_addr (base_addr)
    );

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion. Screen coordinates are driven directly to
// the points of interest rather than scanned through whole frames.

module tb_sprite_motion;

    localparam int CORDW = 12;
    localparam int ADDRW = 11;
    localparam int V_RES = 1080;
    localparam int H_RES = 1920;

    logic             clk_pix = 1'b0;
    logic             rst;
    logic [CORDW-1:0] sx, sy;
    logic             run, dir_in, load;
    logic [CORDW-1:0] load_x, load_y;
    logic [CORDW-1:0] sprx, spry;
    logic [ADDRW-1:0] base_addr;
    logic             spr_start, animate, dir;

    int checks = 0;
    int errors = 0;

    sprite_motion dut (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .sx        (sx),
        .sy        (sy),
        .run       (run),
        .dir_in    (dir_in),
        .load      (load),
        .load_x    (load_x),
        .load_y    (load_y),
        .sprx      (sprx),
        .spry      (spry),
        .base_addr (base_addr),
        .spr_start (spr_start),
        .animate   (animate),
        .dir       (dir)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic cycle();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic do_load(input int x, input int y);
        sy = 0; sx = 5;
        load = 1'b1; load_x = CORDW'(x); load_y = CORDW'(y);
        cycle();
        load = 1'b0;
    endtask

    task automatic do_tick(input logic r, input logic d);
        sy = CORDW'(V_RES); sx = 0; run = r; dir_in = d;
        cycle();
        sx = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sx = 0; sy = 0; run = 0; dir_in = 0; load = 0; load_x = 0; load_y = 0;
        cycle(); cycle();
        checks++; if (sprx !== 12'd0)     begin errors++; $display("FAIL reset_sprx: got %0d, expected 0", sprx); end
        checks++; if (spry !== 12'd420)   begin errors++; $display("FAIL reset_spry: got %0d, expected 420", spry); end
        checks++; if (base_addr !== 11'd0) begin errors++; $display("FAIL reset_base: got %0d, expected 0", base_addr); end
        checks++; if ({spr_start, animate, dir} !== 3'b001) begin errors++; $display("FAIL reset_flags: got %b, expected 001", {spr_start, animate, dir}); end
        rst = 1'b0;
        cycle();
    endtask

`ifdef SPRITE_BOUNCE_EN
    task automatic test_bounce();
        do_load(0, 420);
        do_tick(1'b1, 1'b1);
        checks++; if (sprx !== 12'd0 || dir !== 1'b0) begin errors++; $display("FAIL bounce_left_clamp: got x=%0d dir=%0d, expected x=0 dir=0", sprx, dir); end
        do_load(1530, 420);
        do_tick(1'b1, 1'b1);
        checks++; if (sprx !== 12'd1536 || dir !== 1'b1) begin errors++; $display("FAIL bounce_right_clamp: got x=%0d dir=%0d, expected x=1536 dir=1", sprx, dir); end
        do_tick(1'b1, 1'b0);
        checks++; if (sprx !== 12'd1530 || dir !== 1'b1) begin errors++; $display("FAIL bounce_return: got x=%0d dir=%0d, expected x=1530 dir=1", sprx, dir); end
    endtask
`else
    task automatic test_wrap();
        do_load(4, 420);
        do_tick(1'b1, 1'b1);
        checks++; if (sprx !== 12'd2198 || dir !== 1'b1) begin errors++; $display("FAIL wrap_left: got x=%0d dir=%0d, expected x=2198 dir=1", sprx, dir); end
        checks++; if (animate !== 1'b1) begin errors++; $display("FAIL wrap_animate: got %0d, expected 1", animate); end
        do_tick(1'b1, 1'b1);
        checks++; if (sprx !== 12'd2192) begin errors++; $display("FAIL wrap_left2: got %0d, expected 2192", sprx); end
        do_load(6, 420);
        do_tick(1'b1, 1'b1);
        checks++; if (sprx !== 12'd0) begin errors++; $display("FAIL wrap_left_exact: got %0d, expected 0", sprx); end
        do_load(2196, 420);
        do_tick(1'b1, 1'b0);
        checks++; if (sprx !== 12'd2 || dir !== 1'b0) begin errors++; $display("FAIL wrap_right: got x=%0d dir=%0d, expected x=2 dir=0", sprx, dir); end
        do_load(2194, 420);
        do_tick(1'b1, 1'b0);
        checks++; if (sprx !== 12'd0) begin errors++; $display("FAIL wrap_right_exact: got %0d, expected 0", sprx); end
    endtask
`endif

    task automatic test_frame_seq();
        int exp_b;
        do_load(0, 420);
        checks++; if (base_addr !== 11'd0) begin errors++; $display("FAIL seq_load_clear: got %0d, expected 0", base_addr); end
        for (int k = 1; k <= 64; k++) begin
            do_tick(1'b1, 1'b0);
            exp_b = -1;
            case (k)
                15: exp_b = 0;
                16: exp_b = 640;
                31: exp_b = 640;
                32: exp_b = 0;
                47: exp_b = 0;
                48: exp_b = 1280;
                64: exp_b = 0;
                default: exp_b = -1;
            endcase
            if (exp_b >= 0) begin
                checks++;
                if (base_addr !== ADDRW'(exp_b)) begin errors++; $display("FAIL seq_tick%0d: got %0d, expected %0d", k, base_addr, exp_b); end
            end
        end
`ifndef SPRITE_BOUNCE_EN
        checks++; if (sprx !== 12'd384) begin errors++; $display("FAIL seq_sprx64: got %0d, expected 384", sprx); end
`endif
    endtask

    task automatic test_pause();
        do_load(0, 420);
        for (int k = 0; k < 20; k++) do_tick(1'b1, 1'b0);
        checks++; if (base_addr !== 11'd640) begin errors++; $display("FAIL pause_pre_base: got %0d, expected 640", base_addr); end
`ifndef SPRITE_BOUNCE_EN
        checks++; if (sprx !== 12'd120) begin errors++; $display("FAIL pause_pre_sprx: got %0d, expected 120", sprx); end
`endif
        for (int k = 0; k < 20; k++) do_tick(1'b0, 1'b0);
        checks++; if (base_addr !== 11'd640) begin errors++; $display("FAIL pause_base: got %0d, expected 640", base_addr); end
`ifndef SPRITE_BOUNCE_EN
        checks++; if (sprx !== 12'd120) begin errors++; $display("FAIL pause_sprx: got %0d, expected 120", sprx); end
`endif
        checks++; if (animate !== 1'b1) begin errors++; $display("FAIL pause_animate: got %0d, expected 1", animate); end
        // Hold count resumes from 4: twelve more running ticks reach the next step.
        for (int k = 0; k < 11; k++) do_tick(1'b1, 1'b0);
        checks++; if (base_addr !== 11'd640) begin errors++; $display("FAIL pause_resume11: got %0d, expected 640", base_addr); end
        do_tick(1'b1, 1'b0);
        checks++; if (base_addr !== 11'd0) begin errors++; $display("FAIL pause_resume12: got %0d, expected 0", base_addr); end
    endtask

    task automatic test_start_line();
        do_load(0, 0);
        sy = 1123; sx = 1920; cycle(); sx = 1921;
        checks++; if (spr_start !== 1'b0) begin errors++; $display("FAIL start_y0_early: got %0d, expected 0", spr_start); end
        sy = 1124; sx = 1920; cycle(); sx = 1921;
        checks++; if (spr_start !== 1'b1) begin errors++; $display("FAIL start_y0: got %0d, expected 1", spr_start); end
        cycle();
        checks++; if (spr_start !== 1'b0) begin errors++; $display("FAIL start_y0_width: got %0d, expected 0", spr_start); end
        do_load(0, 420);
        sy = 419; sx = 1919; cycle(); sx = 1920;
        checks++; if (spr_start !== 1'b0) begin errors++; $display("FAIL start_y420_sx: got %0d, expected 0", spr_start); end
        cycle(); sx = 1921;
        checks++; if (spr_start !== 1'b1) begin errors++; $display("FAIL start_y420: got %0d, expected 1", spr_start); end
        sy = 420; sx = 1920; cycle();
        checks++; if (spr_start !== 1'b0) begin errors++; $display("FAIL start_y420_late: got %0d, expected 0", spr_start); end
        do_load(0, 1125);
        sy = 1124; sx = 1920; cycle();
        checks++; if (spr_start !== 1'b0) begin errors++; $display("FAIL start_out_of_range: got %0d, expected 0", spr_start); end
    endtask

    task automatic test_load_on_tick();
        do_load(0, 420);
        for (int k = 0; k < 16; k++) do_tick(1'b1, 1'b0);
        checks++; if (base_addr !== 11'd640) begin errors++; $display("FAIL lot_pre_base: got %0d, expected 640", base_addr); end
        sy = CORDW'(V_RES); sx = 0; run = 1'b1; dir_in = 1'b0;
        load = 1'b1; load_x = 100; load_y = 420;
        cycle();
        load = 1'b0; sx = 1;
        checks++; if (sprx !== 12'd100) begin errors++; $display("FAIL lot_sprx: got %0d, expected 100", sprx); end
        checks++; if (base_addr !== 11'd0) begin errors++; $display("FAIL lot_base: got %0d, expected 0", base_addr); end
        checks++; if (animate !== 1'b1) begin errors++; $display("FAIL lot_animate: got %0d, expected 1", animate); end
        for (int k = 0; k < 15; k++) do_tick(1'b1, 1'b0);
        checks++; if (base_addr !== 11'd0) begin errors++; $display("FAIL lot_hold15: got %0d, expected 0", base_addr); end
        do_tick(1'b1, 1'b0);
        checks++; if (base_addr !== 11'd640) begin errors++; $display("FAIL lot_hold16: got %0d, expected 640", base_addr); end
    endtask

    task automatic test_reset_midline();
        // spr_start is high and base_addr nonzero when reset hits mid-line.
        sy = 419; sx = 1920; cycle();
        sy = 100; sx = 700;
        checks++; if (spr_start !== 1'b1) begin errors++; $display("FAIL mid_pre_start: got %0d, expected 1", spr_start); end
        rst = 1'b1;
        #1;
        checks++; if (sprx !== 12'd0 || spry !== 12'd420) begin errors++; $display("FAIL mid_pos: got x=%0d y=%0d, expected x=0 y=420", sprx, spry); end
        checks++; if (base_addr !== 11'd0) begin errors++; $display("FAIL mid_base: got %0d, expected 0", base_addr); end
        checks++; if ({spr_start, animate, dir} !== 3'b001) begin errors++; $display("FAIL mid_flags: got %b, expected 001", {spr_start, animate, dir}); end
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (spr_start !== 1'b0 || animate !== 1'b0) begin errors++; $display("FAIL mid_quiet%0d: got start=%0d anim=%0d, expected 0 0", k, spr_start, animate); end
        end
        do_tick(1'b0, 1'b0);
        checks++; if (animate !== 1'b1) begin errors++; $display("FAIL mid_first_tick: got %0d, expected 1", animate); end
        sy = 419; sx = CORDW'(H_RES); cycle(); sx = 1921;
        checks++; if (spr_start !== 1'b1) begin errors++; $display("FAIL mid_first_start: got %0d, expected 1", spr_start); end
    endtask

    initial begin
        test_reset();
`ifdef SPRITE_BOUNCE_EN
        test_bounce();
`else
        test_wrap();
`endif
        test_frame_seq();
        test_pause();
        test_start_line();
        test_load_on_tick();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
